// File: rtl/bit_index_encoder_if.sv
// Handshake bundle for bit_index_encoder: vector request in, one-index-per-beat stream out.
// Status outputs (count, zero_drop) travel with the bus.
interface bit_index_encoder_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] out_onehot;
  logic             out_last;
  logic [IDX_W:0]   count;
  logic             zero_drop;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_last, count, zero_drop
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_last, count, zero_drop
  );
endinterface

// File: rtl/bit_index_encoder.sv
// Serialises a multi-hot vector into one beat per set bit, lowest index first.
// All outputs derive from the state register, the pending vector and registered status.
module bit_index_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_index_encoder_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] pending_reg;
  logic [IDX_W:0]   count_reg;
  logic             zero_drop_reg;

  logic [WIDTH-1:0] lowbit;
  logic [IDX_W-1:0] idx_enc;
  logic             single;
  logic [IDX_W:0]   pop_next;
  logic             busy;

  assign busy = (state_reg == BUSY);

  // Two's-complement trick isolates the lowest set bit of pending.
  assign lowbit = pending_reg & (~pending_reg + WIDTH'(1));
  assign single = (|pending_reg) && (pending_reg == lowbit);

  // Each index bit is the OR of the one-hot positions whose index has that bit set.
  for (genvar gi = 0; gi < IDX_W; gi++) begin : g_enc
    logic [WIDTH-1:0] sel;
    always_comb begin
      sel = '0;
      for (int b = 0; b < WIDTH; b++) begin
        sel[b] = b[gi];
      end
    end
    assign idx_enc[gi] = |(lowbit & sel);
  end

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_next = pop_next + (IDX_W+1)'(bus.in_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      count_reg     <= '0;
      zero_drop_reg <= 1'b0;
    end else begin
      zero_drop_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            pending_reg <= bus.in_vec;
            count_reg   <= pop_next;
            if (bus.in_vec == '0) begin
              zero_drop_reg <= 1'b1;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.out_ready) begin
            pending_reg <= pending_reg & ~lowbit;
            if (single) begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = !busy;
  assign bus.out_valid  = busy;
  assign bus.out_idx    = busy ? idx_enc : '0;
  assign bus.out_onehot = busy ? lowbit : '0;
  assign bus.out_last   = busy && single;
  assign bus.count      = count_reg;
  assign bus.zero_drop  = zero_drop_reg;

endmodule

// File: tb/tb_bit_index_encoder.sv
// Scoreboard bench: stimulus pushes expected beats from a set-bit list model; a negedge monitor pops and compares.
module tb_bit_index_encoder;

  typedef struct {
    logic [2:0] idx;
    logic       last;
    logic [3:0] cnt;
  } beat_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  bit   rand_ready = 0;

  beat_t bq[$];
  int    zq[$];

  bit         prev_stall = 0;
  logic [2:0] prev_idx;
  logic       prev_last;

  bit_index_encoder_if #(.WIDTH(8), .IDX_W(3)) bus ();

  bit_index_encoder #(.WIDTH(8), .IDX_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: list the set bits ascending; the final one carries last.
  task automatic model_push(input logic [7:0] v);
    int n;
    int seen;
    beat_t b;
    n = $countones(v);
    seen = 0;
    if (n == 0) begin
      zq.push_back(0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          seen++;
          b.idx  = 3'(i);
          b.last = (seen == n);
          b.cnt  = 4'(n);
          bq.push_back(b);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    @(posedge clk);
    model_push(v);
    $display("send vec=%02h", v);
    #1;
    bus.in_valid = 1'b0;
    bus.in_vec   = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((bq.size() != 0 || !bus.in_ready) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Back-to-back occupancy: k busy cycles then idle on the next.
  task automatic check_span(input int k, input string nm);
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      chk({nm, "_busy_ready"}, bus.in_ready, 0);
      chk({nm, "_busy_valid"}, bus.out_valid, 1);
    end
    @(negedge clk);
    chk({nm, "_done_ready"}, bus.in_ready, 1);
    chk({nm, "_done_valid"}, bus.out_valid, 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (zq.size() != 0) begin
        void'(zq.pop_front());
        chk("zero_drop", bus.zero_drop, 1);
        chk("zero_count", bus.count, 0);
        chk("zero_no_beat", bus.out_valid, 0);
        $display("zero_drop seen=%0b count=%0d", bus.zero_drop, bus.count);
      end else if (bus.zero_drop) begin
        chk("zero_drop_unexpected", bus.zero_drop, 0);
      end
      if (bus.out_valid) begin
        if (prev_stall) begin
          chk("stall_idx", bus.out_idx, prev_idx);
          chk("stall_last", bus.out_last, prev_last);
        end
        if (bq.size() == 0) begin
          chk("unexpected_beat", bus.out_valid, 0);
          prev_stall = 0;
        end else if (bus.out_ready) begin
          beat_t e;
          e = bq.pop_front();
          chk("beat_idx", bus.out_idx, e.idx);
          chk("beat_onehot", bus.out_onehot, 32'h1 << e.idx);
          chk("beat_last", bus.out_last, e.last);
          chk("beat_count", bus.count, e.cnt);
          $display("beat idx=%0d onehot=%02h last=%0b count=%0d", bus.out_idx, bus.out_onehot, bus.out_last, bus.count);
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_idx   = bus.out_idx;
          prev_last  = bus.out_last;
        end
      end else begin
        prev_stall = 0;
        chk("idle_outputs_zero", {bus.out_idx, bus.out_onehot, bus.out_last}, 0);
      end
    end
  end

  // Random backpressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vec   = 8'h00;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_idx_onehot_last", {bus.out_idx, bus.out_onehot, bus.out_last}, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_zero_drop", bus.zero_drop, 0);
    $display("reset state checked");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single bits
    for (int i = 0; i < 8; i++) begin
      send(8'(1 << i));
      wait_drain();
    end

    // Multi-hot at full rate
    send(8'hA5);
    check_span(4, "a5");
    wait_drain();

    // Backpressure
    bus.out_ready = 1'b0;
    send(8'hC0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_idx", bus.out_idx, 6);
      chk("bp_last", bus.out_last, 0);
      chk("bp_ready_low", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Zero vector
    send(8'h00);
    @(negedge clk);
    chk("zv_in_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("zv_pulse_one_cycle", bus.zero_drop, 0);
    wait_drain();

    // Full vector
    send(8'hFF);
    check_span(8, "ff");
    wait_drain();

    // Reset mid-vector
    send(8'h0F);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("amid_out_valid", bus.out_valid, 0);
    chk("amid_in_ready", bus.in_ready, 1);
    chk("amid_count", bus.count, 0);
    chk("amid_idx", bus.out_idx, 0);
    bq.delete();
    zq.delete();
    $display("async reset mid-vector");
    #10 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    send(8'h10);
    wait_drain();

    // Random traffic with random backpressure
    rand_ready = 1;
    for (int t = 0; t < 40; t++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      send(v);
    end
    wait_drain();
    rand_ready = 0;
    bus.out_ready = 1'b1;
    wait_drain();
    chk("final_queue_empty", bq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
